// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory and
// registers the returned word into the IF/ID pipeline register.
//
// Control semantics: there is no valid/ready handshake with the instruction
// memory. It answers imem_pc combinationally in the same cycle. The decoder
// side sees if_id_valid, and a word is delivered on every edge that is not
// reset, redirect, done-hold or stall. Priority per edge is
// rst > redirect > fetch_done hold > stall > advance.
module fetch_unit #(
    parameter int                PC_W     = 8,
    parameter int                INSTR_W  = 32,
    parameter logic [PC_W-1:0]   RESET_PC = 8'h00,
    parameter logic [PC_W-1:0]   LAST_PC  = 8'hFC,
    parameter int                CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [PC_W-1:0]      redirect_pc,
    output logic [PC_W-1:0]      imem_pc,
    input  logic [INSTR_W-1:0]   imem_instr,
    output logic [PC_W-1:0]      if_id_pc,
    output logic [INSTR_W-1:0]   if_id_instr,
    output logic                 if_id_valid,
    output logic                 fetch_done,
    output logic [CNT_W-1:0]     fetch_count
);

    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  redirect_aligned;
    logic [PC_W-1:0]  pc_plus4;
    logic [CNT_W-1:0] count_next;
    logic             at_last;

    // Derived values: word-aligned redirect target, sequential PC, saturating count.
    always_comb begin
        redirect_aligned = {redirect_pc[PC_W-1:2], 2'b00};
        pc_plus4         = pc + PC_W'(4);
        at_last          = (pc == LAST_PC);
        count_next       = fetch_count;
        if (fetch_count != {CNT_W{1'b1}}) begin
            count_next = fetch_count + CNT_W'(1);
        end
    end

    // PC, IF/ID register, end-of-program flag and delivery counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_pc    <= '0;
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
            fetch_done  <= 1'b0;
            fetch_count <= '0;
        end else if (redirect) begin
            // One bubble: the target word is fetched on the next edge.
            pc          <= redirect_aligned;
            if_id_valid <= 1'b0;
            fetch_done  <= 1'b0;
        end else if (fetch_done) begin
            // Program ended: keep PC parked on the last word, emit bubbles.
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if_id_pc    <= pc;
            if_id_instr <= imem_instr;
            if_id_valid <= 1'b1;
            fetch_count <= count_next;
            if (at_last) begin
                // Last word is delivered once; PC never wraps back to 0.
                fetch_done <= 1'b1;
            end else begin
                pc <= pc_plus4;
            end
        end
    end

    assign imem_pc = pc;

endmodule
